mpt_walk_arbiter: RTL and testbench
===================================

Name: mpt_walk_arbiter

Overview:
- Shares one MPT page-table walker (mpt_top instance) among NUM_REQ requesters, e.g. I-side and D-side PLB miss handlers.
- Accepts one walk request at a time using round-robin priority and sequences the walker's enable, address and access-type inputs.
- Waits for the walk to complete, then returns the PLB entry, allow and fault result to the requester that was granted.
- Sits between the per-port PLBs and the single walker; the walker's memory port passes through untouched.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  global flush; aborts any walk
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot, at most one bit high)
- req_spa_i  in  NUM_REQ x $bits(spa_t_u)  per-requester physical address
- req_access_i  in  NUM_REQ x $bits(mpt_access_e)  per-requester access type
- rsp_valid_o  out  NUM_REQ  per-requester one-cycle completion pulse
- rsp_entry_o  out  plb_entry_t  returned PLB entry (shared by all requesters)
- rsp_allow_o  out  1  access allowed
- rsp_access_fault_o  out  1  access page fault
- rsp_format_error_o  out  page_format_fault_e  format fault
- rsp_timeout_o  out  1  watchdog abort (tied 0 without the optional feature)
- ptw_enable_o, addr_valid_o  out  1  to walker ptw_enable_i / addr_valid_i
- ptw_flush_o  out  1  to walker flush_i
- ptw_spa_o  out  spa_t_u  to walker spa_i
- ptw_access_o  out  mpt_access_e  to walker access_type_i
- ptw_busy_i, ptw_valid_i, access_page_fault_i, allow_i  in  1  from walker
- format_error_i  in  page_format_fault_e  from walker
- plb_entry_i  in  plb_entry_t  from walker

Behaviour:
- Reset: FSM=IDLE, round-robin pointer=0, all outputs 0 (enums at encoding 0), latched request cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first requester with req_valid_i set, searching from the pointer upward and wrapping modulo NUM_REQ.
  - Assert req_ready_o for that requester combinationally in the same cycle.
  - On the handshake, latch the SPA, access type and owner index, then go to ISSUE.
  - Update the pointer to owner+1, wrapping modulo NUM_REQ.
- ISSUE (1 cycle):
  - Assert ptw_enable_o and addr_valid_o.
  - Go to WAIT.
- WAIT:
  - ptw_enable_o stays high. addr_valid_o is low.
  - ptw_spa_o and ptw_access_o hold the latched values from ISSUE until leaving RESP.
  - Completion condition: ptw_valid_i OR access_page_fault_i OR format_error_i non-zero.
  - On completion, capture plb_entry_i, allow_i and both fault fields into the response registers, then go to RESP.
- RESP (1 cycle):
  - Pulse rsp_valid_o[owner]; the payload is valid in this cycle only.
  - Deassert ptw_enable_o.
  - Go to IDLE. No new grant is given in RESP.
- Minimum latency from handshake to rsp_valid: 3 cycles (ISSUE, WAIT with walker done in its first cycle, RESP).
- Requesters must hold req_valid_i, SPA and access type stable until req_ready_o is high.
- flush_i:
  - In any state, the FSM goes to IDLE on the next edge.
  - ptw_flush_o = flush_i, passed through combinationally.
  - No rsp_valid_o is issued for the aborted walk. The pointer is kept.
  - Flush in RESP suppresses that cycle's rsp_valid pulse; flush has priority over completion.
- Flush in IDLE with a request present: no grant that cycle (req_ready_o is gated by flush_i).
- Completion arriving outside WAIT is ignored.
- Asynchronous reset mid-walk: everything returns to reset values immediately; the walker is reset by the same rst_ni.
- NUM_REQ=1: the arbiter degenerates to a sequencer; the pointer stays 0.

Optional Feature:
- Macro: MPT_ARB_WATCHDOG_EN.
- With the macro: a counter of width $clog2(TIMEOUT_CYCLES+1) clears in ISSUE and increments in WAIT.
- When it reaches TIMEOUT_CYCLES without completion:
  - Pulse ptw_flush_o for 1 cycle and go to RESP.
  - In RESP, rsp_timeout_o=1, rsp_access_fault_o=1, rsp_allow_o=0, and the entry is zeroed.
- Without the macro: no counter, rsp_timeout_o is tied 0, and WAIT waits indefinitely.

Decomposition:
- Add to mpt_pkg:
  - arb_state_e enum (IDLE, ISSUE, WAIT, RESP).
  - MPT_ARB_MAX_REQ=8 constant.
- Existing package types are reused: spa_t_u, mpt_access_e, plb_entry_t, page_format_fault_e.
- One sub-module: mpt_rr_picker, a combinational round-robin priority selector.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.

Test Plan:
- Single request:
  - Stimulus: req 0 with spa=0x8000_1000, access=read; walker asserts ptw_valid_i with allow_i=1 two cycles after ptw_enable_o.
  - Response: rsp_valid_o=2'b01 exactly once, rsp_allow_o=1, entry matches, ptw_spa_o stable throughout.
- Contention:
  - Stimulus: req 0 and req 1 both valid continuously, pointer=0.
  - Response: grants alternate 0,1,0,1; each rsp_valid goes to the correct owner; never two walks overlap.
- Fault:
  - Stimulus: walker returns access_page_fault_i=1 for req 1.
  - Response: rsp_valid_o=2'b10, rsp_access_fault_o=1, rsp_allow_o=0.
- Format error:
  - Stimulus: walker returns a non-zero format_error_i.
  - Response: the same value appears on rsp_format_error_o in the RESP cycle.
- Flush:
  - Stimulus: flush_i in WAIT, then again in the RESP cycle.
  - Response: no rsp_valid pulse either time, ptw_flush_o mirrors flush_i, FSM returns to IDLE, next grant follows the retained pointer.
- Watchdog (MPT_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=16):
  - Stimulus: walker never completes.
  - Response: ptw_flush_o pulses at WAIT cycle 16; rsp_timeout_o=1 and rsp_access_fault_o=1 on the owner's rsp_valid.

Source files
------------

// File: rtl/mpt_pkg.sv
// Shared MPT types plus the walk-arbiter additions (arb_state_e, MPT_ARB_MAX_REQ).
package mpt_pkg;

    localparam int MPT_ARB_MAX_REQ = 8;
    localparam int SPA_W           = 34;

    // Supervisor physical address: raw view or page/offset view.
    typedef union packed {
        logic [SPA_W-1:0] raw;
        struct packed {
            logic [21:0] ppn;
            logic [11:0] off;
        } f;
    } spa_t_u;

    typedef enum logic [1:0] {
        MPT_ACCESS_READ  = 2'd0,
        MPT_ACCESS_WRITE = 2'd1,
        MPT_ACCESS_EXEC  = 2'd2
    } mpt_access_e;

    typedef enum logic [1:0] {
        FMT_NONE       = 2'd0,
        FMT_RESERVED   = 2'd1,
        FMT_MISALIGNED = 2'd2,
        FMT_BAD_LEVEL  = 2'd3
    } page_format_fault_e;

    typedef struct packed {
        logic        valid;
        logic [21:0] ppn;
        logic [2:0]  perm;
    } plb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mpt_walk_arbiter_if.sv
// Requester-side bundle of the walk arbiter: request handshake and shared response.
interface mpt_walk_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import mpt_pkg::*;

    logic               [NUM_REQ-1:0] req_valid_i;
    logic               [NUM_REQ-1:0] req_ready_o;
    spa_t_u             [NUM_REQ-1:0] req_spa_i;
    mpt_access_e        [NUM_REQ-1:0] req_access_i;
    logic               [NUM_REQ-1:0] rsp_valid_o;
    plb_entry_t                       rsp_entry_o;
    logic                             rsp_allow_o;
    logic                             rsp_access_fault_o;
    page_format_fault_e               rsp_format_error_o;
    logic                             rsp_timeout_o;

    // Requesters (PLB miss handlers) drive requests and consume responses.
    modport master (
        output req_valid_i, req_spa_i, req_access_i,
        input  req_ready_o, rsp_valid_o, rsp_entry_o, rsp_allow_o,
               rsp_access_fault_o, rsp_format_error_o, rsp_timeout_o
    );

    // The arbiter accepts requests and produces responses.
    modport slave (
        input  req_valid_i, req_spa_i, req_access_i,
        output req_ready_o, rsp_valid_o, rsp_entry_o, rsp_allow_o,
               rsp_access_fault_o, rsp_format_error_o, rsp_timeout_o
    );
endinterface

// File: rtl/mpt_rr_picker.sv
// Combinational round-robin selector: first set request at or above the pointer, wrapping.
module mpt_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic          w_found;
    logic [IW-1:0] w_pos;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/mpt_walk_arbiter.sv
// Shares one MPT page-table walker among NUM_REQ requesters with round-robin grants.
// Optional MPT_ARB_WATCHDOG_EN: aborts a walk after TIMEOUT_CYCLES WAIT cycles and
// returns a timeout/access-fault response to the owner.
module mpt_walk_arbiter
    import mpt_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    mpt_walk_arbiter_if.slave  req_if,
    output logic               ptw_enable_o,
    output logic               addr_valid_o,
    output logic               ptw_flush_o,
    output spa_t_u             ptw_spa_o,
    output mpt_access_e        ptw_access_o,
    input  logic               ptw_busy_i,
    input  logic               ptw_valid_i,
    input  logic               access_page_fault_i,
    input  logic               allow_i,
    input  page_format_fault_e format_error_i,
    input  plb_entry_t         plb_entry_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > MPT_ARB_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mpt_walk_arbiter: parameter out of range");
    end

    arb_state_e         r_state, w_next;
    logic [IW-1:0]      r_ptr, r_owner, w_idx, w_ptr_nxt;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_any, w_hs, w_done, w_cap, w_wd_fire;
    spa_t_u             r_spa;
    mpt_access_e        r_access;
    plb_entry_t         r_entry;
    logic               r_allow, r_afault;
    page_format_fault_e r_ferr;
    logic               w_unused_busy;

    // Walker busy is informational only; completion is judged from the result signals.
    assign w_unused_busy = ptw_busy_i;

    mpt_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
        .i_req (req_if.req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_done    = ptw_valid_i | access_page_fault_i | (format_error_i != FMT_NONE);
    assign w_ptr_nxt = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

`ifdef MPT_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] r_wdog;
    logic           r_timeout;

    // Fires in the TIMEOUT_CYCLES-th WAIT cycle; a completion that same cycle wins.
    assign w_wd_fire = (r_state == WAIT) && !flush_i && !w_done &&
                       (r_wdog == WDW'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared in ISSUE, counts WAIT cycles; timeout response overrides payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ISSUE)     r_wdog <= '0;
            else if (r_state == WAIT) r_wdog <= r_wdog + 1'b1;
            if (w_cap)                r_timeout <= 1'b0;
            else if (w_wd_fire)       r_timeout <= 1'b1;
        end
    end

    assign req_if.rsp_timeout_o = r_timeout;
`else
    assign w_wd_fire            = 1'b0;
    assign req_if.rsp_timeout_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state and handshake/walker controls; flush overrides everything.
    always_comb begin
        w_next              = r_state;
        w_hs                = 1'b0;
        w_cap               = 1'b0;
        ptw_enable_o        = 1'b0;
        addr_valid_o        = 1'b0;
        req_if.req_ready_o  = '0;
        req_if.rsp_valid_o  = '0;
        case (r_state)
            IDLE: begin
                if (!flush_i && w_any) begin
                    req_if.req_ready_o = w_gnt;
                    w_hs               = 1'b1;
                    w_next             = ISSUE;
                end
            end
            ISSUE: begin
                ptw_enable_o = 1'b1;
                addr_valid_o = 1'b1;
                w_next       = WAIT;
            end
            WAIT: begin
                ptw_enable_o = 1'b1;
                if (w_done) begin
                    w_cap  = !flush_i;
                    w_next = RESP;
                end else if (w_wd_fire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (!flush_i) req_if.rsp_valid_o = NUM_REQ'(1) << r_owner;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (flush_i) w_next = IDLE;
    end

    // Latched request, round-robin pointer and response payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_spa    <= '0;
            r_access <= MPT_ACCESS_READ;
            r_entry  <= '0;
            r_allow  <= 1'b0;
            r_afault <= 1'b0;
            r_ferr   <= FMT_NONE;
        end else begin
            if (w_hs) begin
                r_spa    <= req_if.req_spa_i[w_idx];
                r_access <= req_if.req_access_i[w_idx];
                r_owner  <= w_idx;
                r_ptr    <= w_ptr_nxt;
            end
            if (w_cap) begin
                r_entry  <= plb_entry_i;
                r_allow  <= allow_i;
                r_afault <= access_page_fault_i;
                r_ferr   <= format_error_i;
            end else if (w_wd_fire) begin
                r_entry  <= '0;
                r_allow  <= 1'b0;
                r_afault <= 1'b1;
                r_ferr   <= FMT_NONE;
            end
        end
    end

    assign ptw_flush_o               = flush_i | w_wd_fire;
    assign ptw_spa_o                 = r_spa;
    assign ptw_access_o              = r_access;
    assign req_if.rsp_entry_o        = r_entry;
    assign req_if.rsp_allow_o        = r_allow;
    assign req_if.rsp_access_fault_o = r_afault;
    assign req_if.rsp_format_error_o = r_ferr;

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// Directed bench for mpt_walk_arbiter (NUM_REQ=2); the walker is modelled by direct stimulus.
// The watchdog case runs only when MPT_ARB_WATCHDOG_EN is defined.
module tb_mpt_walk_arbiter;
    import mpt_pkg::*;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic               flush_i = 1'b0;
    logic               ptw_enable_o, addr_valid_o, ptw_flush_o;
    spa_t_u             ptw_spa_o;
    mpt_access_e        ptw_access_o;
    logic               ptw_busy_i = 1'b0;
    logic               ptw_valid_i = 1'b0;
    logic               access_page_fault_i = 1'b0;
    logic               allow_i = 1'b0;
    page_format_fault_e format_error_i = FMT_NONE;
    plb_entry_t         plb_entry_i = '0;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [33:0] SPA0 = 34'h0_8000_1000;
    localparam logic [33:0] SPA1 = 34'h1_2345_6000;
    localparam logic [33:0] A0   = 34'h0_1111_0000;
    localparam logic [33:0] A1   = 34'h2_2222_0000;

    mpt_walk_arbiter_if #(.NUM_REQ(2)) rif ();

    mpt_walk_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .req_if              (rif),
        .ptw_enable_o        (ptw_enable_o),
        .addr_valid_o        (addr_valid_o),
        .ptw_flush_o         (ptw_flush_o),
        .ptw_spa_o           (ptw_spa_o),
        .ptw_access_o        (ptw_access_o),
        .ptw_busy_i          (ptw_busy_i),
        .ptw_valid_i         (ptw_valid_i),
        .access_page_fault_i (access_page_fault_i),
        .allow_i             (allow_i),
        .format_error_i      (format_error_i),
        .plb_entry_i         (plb_entry_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Registers have updated 2 time units after the edge; drive, then settle before sampling.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic plb_entry_t mk_entry(input int p);
        plb_entry_t e;
        e.valid = 1'b1;
        e.ppn   = 22'(p);
        e.perm  = 3'b011;
        return e;
    endfunction

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic wd_early;
        rif.req_valid_i     = '0;
        rif.req_spa_i       = '0;
        rif.req_access_i[0] = MPT_ACCESS_READ;
        rif.req_access_i[1] = MPT_ACCESS_READ;

        // Reset state
        #3;
        settle();
        chk("rst_ready",   64'(rif.req_ready_o), 64'(0));
        chk("rst_ptw_en",  64'({ptw_enable_o, addr_valid_o}), 64'(0));
        chk("rst_rsp",     64'(rif.rsp_valid_o), 64'(0));
        chk("rst_spa",     64'(ptw_spa_o.raw), 64'(0));
        chk("rst_entry",   64'(rif.rsp_entry_o), 64'(0));
        #8 rst_ni = 1'b1;
        cyc();

        // Single request: req 0, walker done two cycles after enable rises
        rif.req_valid_i   = 2'b01;
        rif.req_spa_i[0]  = SPA0;
        settle();
        chk("t1_ready", 64'(rif.req_ready_o), 64'(2'b01));
        cyc();                                   // ISSUE
        rif.req_valid_i = '0;
        settle();
        chk("t1_issue_ctl", 64'({ptw_enable_o, addr_valid_o}), 64'(2'b11));
        chk("t1_issue_spa", 64'(ptw_spa_o.raw), 64'(SPA0));
        chk("t1_issue_acc", 64'(ptw_access_o), 64'(MPT_ACCESS_READ));
        cyc();                                   // WAIT 1
        settle();
        chk("t1_wait_ctl", 64'({ptw_enable_o, addr_valid_o}), 64'(2'b10));
        chk("t1_wait_rsp", 64'(rif.rsp_valid_o), 64'(0));
        cyc();                                   // WAIT 2: walker completes
        ptw_valid_i = 1'b1; allow_i = 1'b1; plb_entry_i = mk_entry(22'h2_0001);
        settle();
        chk("t1_wait2_spa", 64'(ptw_spa_o.raw), 64'(SPA0));
        cyc();                                   // RESP
        ptw_valid_i = 1'b0; allow_i = 1'b0; plb_entry_i = '0;
        settle();
        chk("t1_rsp_valid", 64'(rif.rsp_valid_o), 64'(2'b01));
        chk("t1_rsp_allow", 64'(rif.rsp_allow_o), 64'(1));
        chk("t1_rsp_entry", 64'(rif.rsp_entry_o), 64'(mk_entry(22'h2_0001)));
        chk("t1_rsp_en",    64'(ptw_enable_o), 64'(0));
        chk("t1_rsp_tmo",   64'(rif.rsp_timeout_o), 64'(0));
        chk("t1_rsp_spa",   64'(ptw_spa_o.raw), 64'(SPA0));
        cyc();                                   // IDLE
        settle();
        chk("t1_once", 64'(rif.rsp_valid_o), 64'(0));

        // Async reset mid-walk (pointer is 1, so req 1 is granted)
        rif.req_valid_i     = 2'b10;
        rif.req_spa_i[1]    = SPA1;
        rif.req_access_i[1] = MPT_ACCESS_WRITE;
        settle();
        chk("rst_mid_ready", 64'(rif.req_ready_o), 64'(2'b10));
        cyc();
        rif.req_valid_i = '0;
        cyc();                                   // WAIT
        #1 rst_ni = 1'b0;
        #1;
        chk("rst_mid_en",  64'(ptw_enable_o), 64'(0));
        chk("rst_mid_spa", 64'(ptw_spa_o.raw), 64'(0));
        chk("rst_mid_acc", 64'(ptw_access_o), 64'(0));
        #2 rst_ni = 1'b1;
        cyc();

        // Contention from pointer 0: grants alternate 0,1,0,1
        rif.req_spa_i[0]    = A0;
        rif.req_spa_i[1]    = A1;
        rif.req_access_i[1] = MPT_ACCESS_WRITE;
        rif.req_valid_i     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % 2;
            settle();
            chk("cont_ready", 64'(rif.req_ready_o), 64'(1 << g));
            cyc();                               // ISSUE
            settle();
            chk("cont_spa",   64'(ptw_spa_o.raw), 64'((g == 1) ? A1 : A0));
            chk("cont_busy0", 64'(rif.req_ready_o), 64'(0));
            cyc();                               // WAIT
            ptw_valid_i = 1'b1; allow_i = 1'b1; plb_entry_i = mk_entry(g + 5);
            settle();
            chk("cont_busy1", 64'(rif.req_ready_o), 64'(0));
            cyc();                               // RESP
            ptw_valid_i = 1'b0; allow_i = 1'b0; plb_entry_i = '0;
            settle();
            chk("cont_owner", 64'(rif.rsp_valid_o), 64'(1 << g));
            chk("cont_entry", 64'(rif.rsp_entry_o), 64'(mk_entry(g + 5)));
            chk("cont_busy2", 64'(rif.req_ready_o), 64'(0));
            cyc();                               // IDLE
        end
        rif.req_valid_i = '0;

        // Access fault for req 1
        rif.req_valid_i = 2'b10;
        settle();
        chk("flt_ready", 64'(rif.req_ready_o), 64'(2'b10));
        cyc();
        rif.req_valid_i = '0;
        cyc();                                   // WAIT
        access_page_fault_i = 1'b1;
        cyc();                                   // RESP
        access_page_fault_i = 1'b0;
        settle();
        chk("flt_valid", 64'(rif.rsp_valid_o), 64'(2'b10));
        chk("flt_fault", 64'(rif.rsp_access_fault_o), 64'(1));
        chk("flt_allow", 64'(rif.rsp_allow_o), 64'(0));
        cyc();

        // Format error for req 0; a completion seen in ISSUE is ignored
        rif.req_valid_i = 2'b01;
        settle();
        chk("fmt_ready", 64'(rif.req_ready_o), 64'(2'b01));
        cyc();                                   // ISSUE
        rif.req_valid_i = '0;
        ptw_valid_i     = 1'b1;
        cyc();                                   // WAIT 1
        ptw_valid_i = 1'b0;
        settle();
        chk("early_cmp_en", 64'(ptw_enable_o), 64'(1));
        cyc();                                   // still WAIT
        settle();
        chk("early_cmp_rsp", 64'(rif.rsp_valid_o), 64'(0));
        chk("early_cmp_en2", 64'(ptw_enable_o), 64'(1));
        format_error_i = FMT_MISALIGNED;
        cyc();                                   // RESP
        format_error_i = FMT_NONE;
        settle();
        chk("fmt_valid", 64'(rif.rsp_valid_o), 64'(2'b01));
        chk("fmt_value", 64'(rif.rsp_format_error_o), 64'(FMT_MISALIGNED));
        chk("fmt_afault", 64'(rif.rsp_access_fault_o), 64'(0));
        cyc();

        // Flush in WAIT, then flush in RESP; pointer retained (currently 1)
        rif.req_valid_i = 2'b01;
        settle();
        chk("fl_ready0", 64'(rif.req_ready_o), 64'(2'b01));
        cyc();
        rif.req_valid_i = '0;
        cyc();                                   // WAIT
        flush_i = 1'b1;
        settle();
        chk("fl_wait_pf",  64'(ptw_flush_o), 64'(1));
        chk("fl_wait_rsp", 64'(rif.rsp_valid_o), 64'(0));
        cyc();                                   // IDLE, flush still high
        rif.req_valid_i = 2'b11;
        settle();
        chk("fl_idle_gate", 64'(rif.req_ready_o), 64'(0));
        chk("fl_idle_rsp",  64'(rif.rsp_valid_o), 64'(0));
        flush_i = 1'b0;
        settle();
        chk("fl_idle_pf",  64'(ptw_flush_o), 64'(0));
        chk("fl_ptr_kept", 64'(rif.req_ready_o), 64'(2'b10));
        cyc();                                   // ISSUE owner 1
        rif.req_valid_i = '0;
        cyc();                                   // WAIT
        ptw_valid_i = 1'b1; allow_i = 1'b1; plb_entry_i = mk_entry(7);
        cyc();                                   // RESP
        ptw_valid_i = 1'b0; allow_i = 1'b0; plb_entry_i = '0;
        flush_i = 1'b1;
        settle();
        chk("fl_resp_rsp", 64'(rif.rsp_valid_o), 64'(0));
        chk("fl_resp_pf",  64'(ptw_flush_o), 64'(1));
        cyc();                                   // IDLE
        flush_i = 1'b0;
        rif.req_valid_i = 2'b11;
        settle();
        chk("fl_next_grant", 64'(rif.req_ready_o), 64'(2'b01));
        cyc();
        rif.req_valid_i = '0;
        cyc();                                   // WAIT
        ptw_valid_i = 1'b1; plb_entry_i = mk_entry(9);
        cyc();                                   // RESP
        ptw_valid_i = 1'b0; plb_entry_i = '0;
        settle();
        chk("fl_after_rsp", 64'(rif.rsp_valid_o), 64'(2'b01));
        cyc();

`ifdef MPT_ARB_WATCHDOG_EN
        // Walker never completes: abort in WAIT cycle 16 (pointer is 1, req 0 granted)
        rif.req_valid_i = 2'b01;
        settle();
        chk("wd_ready", 64'(rif.req_ready_o), 64'(2'b01));
        cyc();                                   // ISSUE
        rif.req_valid_i = '0;
        wd_early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cyc();                               // WAIT k
            settle();
            if (k < 16) wd_early = wd_early | ptw_flush_o;
        end
        chk("wd_pf_pulse", 64'(ptw_flush_o), 64'(1));
        chk("wd_pf_early", 64'(wd_early), 64'(0));
        cyc();                                   // RESP
        settle();
        chk("wd_pf_one",  64'(ptw_flush_o), 64'(0));
        chk("wd_valid",   64'(rif.rsp_valid_o), 64'(2'b01));
        chk("wd_timeout", 64'(rif.rsp_timeout_o), 64'(1));
        chk("wd_afault",  64'(rif.rsp_access_fault_o), 64'(1));
        chk("wd_allow",   64'(rif.rsp_allow_o), 64'(0));
        chk("wd_entry",   64'(rif.rsp_entry_o), 64'(0));
        cyc();
`else
        wd_early = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
